alu_program_sequencer: RTL and testbench

//  Programmable controller for the W/B accumulator-ALU datapath (reg W, counter B, 4-op ALU).

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_seq_prog_mem.sv | 38 +++
 rtl/alu_program_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_program_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types for the ALU program sequencer: ALU opcode,
//                8-bit instruction word layout and sequencer FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // ALU select driven to the W/B datapath
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_DIV = 2'd3
    } alu_op_e;

    // Instruction word, MSB first: {halt, rpt[2:0], load_w, cnt, op[1:0]}
    typedef struct packed {
        logic       halt;
        logic [2:0] rpt;
        logic       load_w;
        logic       cnt;
        alu_op_e    op;
    } alu_instr_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_prog_mem
//  Description : DEPTH x instruction register array. Synchronous write,
//                combinational read, synchronous clear on reset.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_prog_mem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  alu_instr_t               i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output alu_instr_t               o_rdata
);

    alu_instr_t r_mem [DEPTH];

    // Store update: reset wipes every word, otherwise write the addressed word
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/alu_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_program_sequencer
//  Description : Loadable-program controller for the W/B accumulator ALU.
//                Steps through the instruction store on start, holding each
//                instruction rpt+1 cycles, and pulses done after a halt
//                instruction or the last store word.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_program_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_prog_we,
    input  logic [$clog2(DEPTH)-1:0] i_prog_addr,
    input  logic [7:0]               i_prog_data,
    input  logic                     i_start,
    output logic [1:0]               o_op,
    output logic                     o_cnt,
    output logic                     o_load_w,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_wr_reject
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] C_LAST_PC = AW'(DEPTH - 1);

    seq_state_e    r_state;
    seq_state_e    w_state_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [2:0]    r_rpt_cnt;
    logic [2:0]    w_rpt_next;
    logic          r_wr_reject;
    logic          w_mem_we;
    logic          w_last_rep;
    alu_instr_t    w_cur;

    // Writes only land while idle; a run always sees a stable program
    assign w_mem_we = i_prog_we && (r_state == S_IDLE);

    alu_seq_prog_mem #(
        .DEPTH (DEPTH)
    ) u_prog_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_waddr (i_prog_addr),
        .i_wdata (alu_instr_t'(i_prog_data)),
        .i_raddr (r_pc),
        .o_rdata (w_cur)
    );

    assign w_last_rep = (r_rpt_cnt == w_cur.rpt);

    // State, program counter and repeat counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_rpt_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_rpt_cnt <= w_rpt_next;
        end
    end

    // Next-state sequencing and control decode
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_rpt_next   = r_rpt_cnt;
        o_op         = 2'd0;
        o_cnt        = 1'b0;
        o_load_w     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_RUN;
                    w_pc_next    = '0;
                    w_rpt_next   = '0;
                end
            end
            S_RUN: begin
                o_op     = w_cur.op;
                o_cnt    = w_cur.cnt;
                o_load_w = w_cur.load_w;
                o_busy   = 1'b1;
                if (w_last_rep) begin
                    w_rpt_next = '0;
                    // Halt and the last store word both end the run; pc never wraps
                    if (w_cur.halt || (r_pc == C_LAST_PC)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_pc_next = r_pc + 1'b1;
                    end
                end else begin
                    w_rpt_next = r_rpt_cnt + 3'd1;
                end
            end
            S_DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Flag program writes attempted while busy, one cycle after the strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_reject <= 1'b0;
        end else begin
            r_wr_reject <= i_prog_we && (r_state != S_IDLE);
        end
    end

    assign o_wr_reject = r_wr_reject;

endmodule
`default_nettype wire

// File: tb/tb_alu_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_program_sequencer
//  Description : Directed self-checking bench for alu_program_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_program_sequencer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_prog_we;
    logic [3:0] i_prog_addr;
    logic [7:0] i_prog_data;
    logic       i_start;
    logic [1:0] o_op;
    logic       o_cnt;
    logic       o_load_w;
    logic       o_busy;
    logic       o_done;
    logic       o_wr_reject;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] prog1  [9];
    logic [1:0] t1_op  [9];
    logic       t1_ld  [9];
    logic       t1_cnt [9];
    int         cycles;
    int         cnt_cycles;

    wire [5:0] w_obs = {o_busy, o_done, o_load_w, o_cnt, o_op};

    alu_program_sequencer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_prog_we   (i_prog_we),
        .i_prog_addr (i_prog_addr),
        .i_prog_data (i_prog_data),
        .i_start     (i_start),
        .o_op        (o_op),
        .o_cnt       (o_cnt),
        .o_load_w    (o_load_w),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_wr_reject (o_wr_reject)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ctl(input logic busy, input logic done, input logic ld,
                                       input logic cn, input logic [1:0] op);
        return {busy, done, ld, cn, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        i_prog_we   = 1'b1;
        i_prog_addr = a;
        i_prog_data = d;
        step();
        i_prog_we   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // cnt x4 (rpt=3), then a halting load_w step, then done; busy for 6 cycles
    task automatic run_trace2(input string tg);
        int bc;
        bc      = 0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 20 && o_busy; k++) begin
            bc++;
            if (k < 4)       chk($sformatf("%s_c%0d", tg, k), 32'(w_obs), 32'(ctl(1, 0, 0, 1, 2'd0)));
            else if (k == 4) chk($sformatf("%s_ld", tg), 32'(w_obs), 32'(ctl(1, 0, 1, 0, 2'd0)));
            else             chk($sformatf("%s_done", tg), 32'(w_obs), 32'(ctl(1, 1, 0, 0, 2'd0)));
            step();
        end
        chk($sformatf("%s_busy_cycles", tg), 32'(bc), 32'd6);
    endtask

    initial begin
        reset       = 1'b1;
        i_prog_we   = 1'b0;
        i_prog_addr = '0;
        i_prog_data = '0;
        i_start     = 1'b0;
        prog1  = '{8'h04, 8'h0C, 8'h0C, 8'h0D, 8'h0C, 8'h0E, 8'h0D, 8'h0F, 8'h88};
        t1_op  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
        t1_ld  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        t1_cnt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        step();
        step();
        reset = 1'b0;
        chk("reset_ctl", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));
        chk("reset_wr_reject", 32'(o_wr_reject), 32'd0);

        // Test 1: nine-word program with op sequence 0,0,0,1,0,2,1,3,0
        for (int i = 0; i < 9; i++) load(4'(i), prog1[i]);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t1_c%0d", i), 32'(w_obs), 32'(ctl(1, 0, t1_ld[i], t1_cnt[i], t1_op[i])));
            step();
        end
        chk("t1_done", 32'(w_obs), 32'(ctl(1, 1, 0, 0, 2'd0)));
        step();
        chk("t1_idle", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));

        // Test 2: repeat count then halt
        do_reset();
        load(4'd0, 8'h34);
        load(4'd1, 8'h88);
        run_trace2("t2");
        chk("t2_idle", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));

        // Test 3: write during RUN is rejected and dropped
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("t3_c0", 32'(w_obs), 32'(ctl(1, 0, 0, 1, 2'd0)));
        chk("t3_no_reject_yet", 32'(o_wr_reject), 32'd0);
        i_prog_we   = 1'b1;
        i_prog_addr = 4'd0;
        i_prog_data = 8'hFF;
        step();
        i_prog_we = 1'b0;
        chk("t3_reject", 32'(o_wr_reject), 32'd1);
        chk("t3_c1", 32'(w_obs), 32'(ctl(1, 0, 0, 1, 2'd0)));
        step();
        chk("t3_reject_pulse", 32'(o_wr_reject), 32'd0);
        chk("t3_c2", 32'(w_obs), 32'(ctl(1, 0, 0, 1, 2'd0)));
        step();
        chk("t3_c3", 32'(w_obs), 32'(ctl(1, 0, 0, 1, 2'd0)));
        step();
        chk("t3_ld", 32'(w_obs), 32'(ctl(1, 0, 1, 0, 2'd0)));
        step();
        chk("t3_done", 32'(w_obs), 32'(ctl(1, 1, 0, 0, 2'd0)));
        step();
        chk("t3_idle", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));
        run_trace2("t3_rerun");

        // Test 4: no halt anywhere, run to end of store without wrapping
        do_reset();
        for (int a = 0; a < DEPTH; a++) load(4'(a), 8'h04);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        cnt_cycles = 0;
        for (int k = 0; k < 40 && o_busy && !o_done; k++) begin
            if (o_cnt) cnt_cycles++;
            step();
        end
        chk("t4_cnt_cycles", 32'(cnt_cycles), 32'(DEPTH));
        chk("t4_done", 32'(w_obs), 32'(ctl(1, 1, 0, 0, 2'd0)));
        step();
        chk("t4_idle", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));

        // Test 5: reset in the 3rd RUN cycle clears FSM and store
        do_reset();
        for (int i = 0; i < 9; i++) load(4'(i), prog1[i]);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        step();
        chk("t5_c2", 32'(w_obs), 32'(ctl(1, 0, 1, 1, 2'd0)));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_after_reset", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("t5_cleared_word0", 32'(w_obs), 32'(ctl(1, 0, 0, 0, 2'd0)));
        cycles = 0;
        for (int k = 0; k < 40 && o_busy && !o_done; k++) begin
            cycles++;
            step();
        end
        chk("t5_run_cycles", 32'(cycles), 32'(DEPTH));
        chk("t5_done", 32'(w_obs), 32'(ctl(1, 1, 0, 0, 2'd0)));

        // Test 6: start held high -> back-to-back runs with one IDLE gap
        do_reset();
        load(4'd0, 8'h84);
        i_start = 1'b1;
        step();
        chk("t6_run1", 32'(w_obs), 32'(ctl(1, 0, 0, 1, 2'd0)));
        step();
        chk("t6_done1", 32'(w_obs), 32'(ctl(1, 1, 0, 0, 2'd0)));
        step();
        chk("t6_gap", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));
        step();
        chk("t6_run2", 32'(w_obs), 32'(ctl(1, 0, 0, 1, 2'd0)));
        step();
        chk("t6_done2", 32'(w_obs), 32'(ctl(1, 1, 0, 0, 2'd0)));
        i_start = 1'b0;
        step();
        chk("t6_idle_a", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));
        step();
        chk("t6_idle_b", 32'(w_obs), 32'(ctl(0, 0, 0, 0, 2'd0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
